// File: rtl/ramb4_byte_to_bit_streamer.sv
// Byte-in, bit-out FIFO built around an external 4096-bit dual-port RAM (512x8 write side, 4096x1 read side).
// Latency: a byte accepted at edge N shows its first bit on OUT_BIT after edge N+2; 1 bit/cycle sustained.
// Backpressure: IN_READY drops once a new byte could overwrite unread bits; OUT_READY=0 holds the buffer head.
module ramb4_byte_to_bit_streamer #(
  parameter int LSB_FIRST = 1
) (
  input  logic        CLKA,
  input  logic        RSTB,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic        OUT_BIT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [12:0] COUNT,
  output logic [8:0]  RAM_ADDRB,
  output logic [7:0]  RAM_DIB,
  output logic        RAM_ENB,
  output logic        RAM_WEB,
  output logic [11:0] RAM_ADDRA,
  output logic        RAM_ENA,
  output logic        RAM_WEA,
  input  logic        RAM_DOA,
  output logic        RAM_RSTA,
  output logic        RAM_RSTB
);

  logic [8:0]  wr_ptr;
  logic [11:0] rd_ptr;
  logic [12:0] count_q;
  logic [12:0] unissued;
  logic [1:0]  occ;
  logic        inflight;
  logic        hold0;
  logic        hold1;
  logic        accept;
  logic        pop;
  logic        issue;
  logic [2:0]  pending;
  logic [2:0]  bit_sel;

  // A byte slot is safe to overwrite only while at most 511 bytes (4088 bits) are outstanding.
  assign IN_READY  = !RSTB && (count_q <= 13'd4088);
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = (occ != 2'd0);
  assign OUT_BIT   = hold0;
  assign pop       = OUT_VALID && OUT_READY;
  assign COUNT     = count_q;

  // Buffer slots that will be taken once the in-flight read lands, net of this cycle's pop.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue   = !RSTB && (unissued != 13'd0) && (pending < 3'd2);

  // MSB-first streaming just mirrors the bit index within each byte.
  assign bit_sel   = (LSB_FIRST != 0) ? rd_ptr[2:0] : (3'd7 - rd_ptr[2:0]);
  assign RAM_ADDRA = {rd_ptr[11:3], bit_sel};
  assign RAM_ENA   = issue;
  assign RAM_WEA   = 1'b0;

  assign RAM_ADDRB = wr_ptr;
  assign RAM_DIB   = IN_DATA;
  assign RAM_ENB   = accept;
  assign RAM_WEB   = accept;

  // Reset never touches RAM contents or its output latches.
  assign RAM_RSTA  = 1'b0;
  assign RAM_RSTB  = 1'b0;

  // Pointers and occupancy counters; unissued only grows after the write edge, so reads never race writes.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      wr_ptr   <= 9'd0;
      rd_ptr   <= 12'd0;
      count_q  <= 13'd0;
      unissued <= 13'd0;
      inflight <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + {8'd0, accept};
      rd_ptr   <= rd_ptr + {11'd0, issue};
      count_q  <= count_q + (accept ? 13'd8 : 13'd0) - {12'd0, pop};
      unissued <= unissued + (accept ? 13'd8 : 13'd0) - {12'd0, issue};
      inflight <= issue;
    end
  end

  // Two-entry output buffer: RAM data is captured one edge after its read was issued.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      occ   <= 2'd0;
      hold0 <= 1'b0;
      hold1 <= 1'b0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) hold0 <= RAM_DOA;
          else             hold1 <= RAM_DOA;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          hold0 <= hold1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            hold0 <= RAM_DOA;
          end else begin
            hold0 <= hold1;
            hold1 <= RAM_DOA;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramb4_byte_to_bit_streamer.sv
// Bench for the byte-to-bit streamer: two instances (LSB-first and MSB-first) share stimulus.
// Each has its own behavioural dual-port RAM; a bit-queue reference model scores every pop.
// Randomized traffic plus directed reset, latency, full, wrap and backpressure scenarios.
module tb_ramb4_byte_to_bit_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_l, out_bit_l, out_valid_l, ram_enb_l, ram_web_l, ram_ena_l, ram_wea_l;
  logic        ram_doa_l, ram_rsta_l, ram_rstb_l;
  logic [12:0] count_l;
  logic [8:0]  ram_addrb_l;
  logic [7:0]  ram_dib_l;
  logic [11:0] ram_addra_l;

  logic        in_ready_m, out_bit_m, out_valid_m, ram_enb_m, ram_web_m, ram_ena_m, ram_wea_m;
  logic        ram_doa_m, ram_rsta_m, ram_rstb_m;
  logic [12:0] count_m;
  logic [8:0]  ram_addrb_m;
  logic [7:0]  ram_dib_m;
  logic [11:0] ram_addra_m;

  always #5 clk = ~clk;

  ramb4_byte_to_bit_streamer #(.LSB_FIRST(1)) u_lsb (
    .CLKA(clk), .RSTB(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready_l),
    .OUT_BIT(out_bit_l), .OUT_VALID(out_valid_l), .OUT_READY(out_ready), .COUNT(count_l),
    .RAM_ADDRB(ram_addrb_l), .RAM_DIB(ram_dib_l), .RAM_ENB(ram_enb_l), .RAM_WEB(ram_web_l),
    .RAM_ADDRA(ram_addra_l), .RAM_ENA(ram_ena_l), .RAM_WEA(ram_wea_l), .RAM_DOA(ram_doa_l),
    .RAM_RSTA(ram_rsta_l), .RAM_RSTB(ram_rstb_l)
  );

  ramb4_byte_to_bit_streamer #(.LSB_FIRST(0)) u_msb (
    .CLKA(clk), .RSTB(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready_m),
    .OUT_BIT(out_bit_m), .OUT_VALID(out_valid_m), .OUT_READY(out_ready), .COUNT(count_m),
    .RAM_ADDRB(ram_addrb_m), .RAM_DIB(ram_dib_m), .RAM_ENB(ram_enb_m), .RAM_WEB(ram_web_m),
    .RAM_ADDRA(ram_addra_m), .RAM_ENA(ram_ena_m), .RAM_WEA(ram_wea_m), .RAM_DOA(ram_doa_m),
    .RAM_RSTA(ram_rsta_m), .RAM_RSTB(ram_rstb_m)
  );

  // Behavioural RAMs: byte port writes 8 bits at addr*8+i, bit port has a registered read.
  logic mem_l [0:4095];
  logic mem_m [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_l[i] = 1'($urandom);
      mem_m[i] = 1'($urandom);
    end
    ram_doa_l = 1'b0;
    ram_doa_m = 1'b0;
  end

  always @(posedge clk) begin
    if (ram_enb_l && ram_web_l)
      for (int i = 0; i < 8; i++) mem_l[int'(ram_addrb_l) * 8 + i] <= ram_dib_l[i];
    if (ram_ena_l) ram_doa_l <= mem_l[ram_addra_l];
  end

  always @(posedge clk) begin
    if (ram_enb_m && ram_web_m)
      for (int i = 0; i < 8; i++) mem_m[int'(ram_addrb_m) * 8 + i] <= ram_dib_m[i];
    if (ram_ena_m) ram_doa_m <= mem_m[ram_addra_m];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected bit order per instance, plus the expected write pointer.
  bit   q_l[$];
  bit   q_m[$];
  int   n_acc = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  int   exp_wp = 0;
  logic exp_rdy, acc, pop, prev_stall, prev_bit_l, prev_bit_m;
  int   last_addrb = 0;
  int   last_addra = 0;
  bit   wrap_b = 0;
  bit   wrap_a = 0;

  initial prev_stall = 1'b0;

  // Scoreboard: compare at the falling edge, then apply what the next rising edge will do.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      exp_rdy = !rst && (q_l.size() <= 4088);
      acc     = in_valid && exp_rdy;
      pop     = !rst && out_valid_l && out_ready;

      chk("count", count_l, q_l.size());
      chk("count_msb", count_m, q_l.size());
      chk("in_ready", {in_ready_l, in_ready_m}, {exp_rdy, exp_rdy});
      chk("wea", {ram_wea_l, ram_wea_m}, 0);
      chk("enb_web", {ram_enb_l, ram_web_l, ram_enb_m, ram_web_m}, {4{acc}});
      if (acc) begin
        chk("addrb", ram_addrb_l, exp_wp);
        chk("dib", ram_dib_l, in_data);
      end
      if (rst) chk("ena_in_rst", {ram_ena_l, ram_ena_m}, 0);
      chk("valid_match", out_valid_m, out_valid_l);
      chk("spurious_vld", out_valid_l && (q_l.size() == 0), 0);
      if (prev_stall) begin
        chk("stall_vld", out_valid_l, 1);
        chk("stall_bit", {out_bit_l, out_bit_m}, {prev_bit_l, prev_bit_m});
      end
      if (pop && q_l.size() > 0) begin
        chk("bit_lsb", out_bit_l, q_l[0]);
        chk("bit_msb", out_bit_m, q_m[0]);
      end

      if (ram_enb_l) begin
        if (last_addrb == 511 && ram_addrb_l == 9'd0) wrap_b = 1;
        last_addrb = int'(ram_addrb_l);
      end
      if (ram_ena_l) begin
        if (last_addra == 4095 && ram_addra_l == 12'd0) wrap_a = 1;
        last_addra = int'(ram_addra_l);
      end

      prev_stall = !rst && out_valid_l && !out_ready;
      prev_bit_l = out_bit_l;
      prev_bit_m = out_bit_m;

      if (rst) begin
        q_l.delete();
        q_m.delete();
        exp_wp = 0;
        last_addrb = 0;
        last_addra = 0;
      end else begin
        if (pop && q_l.size() > 0) begin
          void'(q_l.pop_front());
          void'(q_m.pop_front());
        end
        if (acc) begin
          for (int i = 0; i < 8; i++) begin
            q_l.push_back(in_data[i]);
            q_m.push_back(in_data[7 - i]);
          end
          exp_wp = (exp_wp + 1) % 512;
          n_acc++;
        end
      end
    end
  end

  task automatic push_n(input int n);
    int target = n_acc + n;
    int budget = 0;
    while (n_acc < target && budget < 30000) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    chk("push_done", n_acc, target);
  endtask

  task automatic drain();
    int budget = 0;
    out_ready = 1'b1;
    while ((q_l.size() != 0 || out_valid_l) && budget < 20000) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("drain_left", q_l.size(), 0);
  endtask

  task automatic send_one(input logic [7:0] b);
    out_ready = 1'b1;
    in_data   = b;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("one_rdy", in_ready_l, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("one_lat1", out_valid_l, 0);
    @(posedge clk);
    @(negedge clk);
    chk("one_lat2", out_valid_l, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("one_vld", out_valid_l, 1);
      chk("one_lsb", out_bit_l, b[i]);
      chk("one_msb", out_bit_m, b[7 - i]);
    end
    @(posedge clk);
    @(negedge clk);
    chk("one_end", out_valid_l, 0);
    @(posedge clk); #1;
  endtask

  int c0;

  initial begin
    // Power-up reset, then reset again with traffic in flight.
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    mon_en = 1;
    rst = 1'b0;
    out_ready = 1'b1;
    push_n(3);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'($urandom);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_vld", out_valid_l, 0);
    chk("rst_count", count_l, 0);
    chk("rst_web", ram_web_l, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", in_ready_l, 1);
    @(posedge clk); #1;

    // Single bytes: latency and bit order for both orientations.
    send_one(8'hA5);
    send_one(8'h01);
    send_one(8'h80);

    // Fill to capacity with the output stalled, then release bit by bit.
    out_ready = 1'b0;
    push_n(512);
    @(negedge clk);
    chk("full_count", count_l, 4096);
    chk("full_rdy", in_ready_l, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("pop1_count", count_l, 4095);
    chk("pop1_rdy", in_ready_l, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    @(negedge clk);
    chk("pop8_count", count_l, 4088);
    chk("pop8_rdy", in_ready_l, 1);
    @(posedge clk); #1;
    drain();

    // Long stream through pointer wrap at full rate.
    c0 = cyc;
    out_ready = 1'b1;
    push_n(1500);
    drain();
    chk("throughput", (cyc - c0) <= 12010, 1);
    chk("wrap_addrb", wrap_b, 1);
    chk("wrap_addra", wrap_a, 1);

    // Random valid/ready on both sides.
    for (int k = 0; k < 4000; k++) begin
      in_valid  = ($urandom % 2) == 1;
      in_data   = 8'($urandom);
      out_ready = ($urandom % 2) == 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset while streaming with a read in flight, then a fresh byte.
    out_ready = 1'b1;
    push_n(4);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_vld", out_valid_l, 0);
    chk("mid_rst_count", count_l, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("post_rst_idle", out_valid_l, 0);
    send_one(8'h3C);
    repeat (4) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
